// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane mask helper
// used by the register-file responder.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT      = 3'd1,
        ST_OKAY_LAST = 3'd2,
        ST_ERR1      = 3'd3,
        ST_ERR2      = 3'd4
    } state_t;

    // Byte lanes touched by an aligned access of the given size.
    function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo, input logic [2:0] size);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr_lo;
            HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_slave_ctrl.sv
// Address-phase capture, transfer classification, response FSM and wait counter
// for the AHB-Lite register-file responder.
module ahb_slave_ctrl
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_RW      = 6,
    parameter int          NUM_RO      = 2,
    parameter int          WAIT_STATES = 0,
    parameter int          IDX_W       = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hsel,
    input  logic [31:0]      i_haddr,
    input  logic [1:0]       i_htrans,
    input  logic             i_hwrite,
    input  logic [2:0]       i_hsize,
    input  logic             i_hready,
    output logic             o_hreadyout,
    output logic             o_hresp,
    output logic             o_wr_en,
    output logic             o_rd_en,
    output logic [IDX_W-1:0] o_idx,
    output logic [3:0]       o_mask
);

    localparam int NUM_REGS = NUM_RW + NUM_RO;

    state_t           r_state;
    logic             r_hreadyout;
    logic             r_hresp;
    logic [2:0]       r_wcnt;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_addr_lo;
    logic [2:0]       r_size;
    logic             r_write;

    logic             w_take;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic             w_misaligned;
    logic             w_unused_ok;

    assign w_unused_ok = i_htrans[0];

    // A new address phase is only meaningful where the previous data phase is completing.
    assign w_take = i_hsel && i_hready && i_htrans[1] &&
                    (r_state != ST_WAIT) && (r_state != ST_ERR1);

    assign w_idx        = i_haddr[IDX_W+1:2];
    assign w_misaligned = ((i_hsize == HSIZE_HALF) && i_haddr[0]) ||
                          ((i_hsize == HSIZE_WORD) && (i_haddr[1:0] != 2'b00));
    assign w_err = (i_haddr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2]) ||
                   (32'(w_idx) >= NUM_REGS) ||
                   (i_hsize > HSIZE_WORD) ||
                   w_misaligned ||
                   (i_hwrite && (32'(w_idx) >= NUM_RW));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_wcnt      <= 3'd0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_wcnt == 3'd0) begin
                        r_state     <= ST_OKAY_LAST;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    if (w_take && w_err) begin
                        r_state     <= ST_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                    end else if (w_take && (WAIT_STATES > 0)) begin
                        r_state     <= ST_WAIT;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_OKAY;
                        r_wcnt      <= 3'(WAIT_STATES - 1);
                    end else if (w_take) begin
                        r_state     <= ST_OKAY_LAST;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Transfer attributes are data; the FSM state alone qualifies them.
    always_ff @(posedge i_clk) begin
        if (w_take) begin
            r_idx     <= w_idx;
            r_addr_lo <= i_haddr[1:0];
            r_size    <= i_hsize;
            r_write   <= i_hwrite;
        end
    end

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;
    assign o_wr_en     = (r_state == ST_OKAY_LAST) && r_write;
    assign o_rd_en     = (r_state == ST_OKAY_LAST) && !r_write;
    assign o_idx       = r_idx;
    assign o_mask      = lane_mask(r_addr_lo, r_size);

endmodule

// File: rtl/ahb_slave_regfile.sv
// AHB-Lite responder exposing NUM_RW control registers and NUM_RO live status
// registers as a bank of 32-bit words.
module ahb_slave_regfile
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_RW      = 6,
    parameter int          NUM_RO      = 2,
    parameter int          WAIT_STATES = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESETN,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [3:0]               HPROT,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [31:0]              HRDATA,
    output logic [32*NUM_RW-1:0]     reg_o,
    input  logic [32*NUM_RO-1:0]     ro_i,
    output logic [NUM_RW-1:0]        wr_pulse_o
);

    localparam int NUM_REGS = NUM_RW + NUM_RO;
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic             w_wr_en;
    logic             w_rd_en;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_mask;
    logic [31:0]      w_rdata;
    logic             w_unused_ok;

    logic [31:0]       r_regs [NUM_RW];
    logic [NUM_RW-1:0] r_wr_pulse;

    assign w_unused_ok = ^{HBURST, HPROT};

    ahb_slave_ctrl #(
        .BASE_ADDR   (BASE_ADDR),
        .NUM_RW      (NUM_RW),
        .NUM_RO      (NUM_RO),
        .WAIT_STATES (WAIT_STATES),
        .IDX_W       (IDX_W)
    ) u_ctrl (
        .i_clk       (HCLK),
        .i_rst_n     (HRESETN),
        .i_hsel      (HSEL),
        .i_haddr     (HADDR),
        .i_htrans    (HTRANS),
        .i_hwrite    (HWRITE),
        .i_hsize     (HSIZE),
        .i_hready    (HREADY),
        .o_hreadyout (HREADYOUT),
        .o_hresp     (HRESP),
        .o_wr_en     (w_wr_en),
        .o_rd_en     (w_rd_en),
        .o_idx       (w_idx),
        .o_mask      (w_mask)
    );

    // Commit on the edge that closes the OKAY data phase, lane by lane.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            for (int i = 0; i < NUM_RW; i++) r_regs[i] <= 32'd0;
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_wr_pulse[i] <= w_wr_en && (32'(w_idx) == i);
                if (w_wr_en && (32'(w_idx) == i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_mask[b]) r_regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_rd_en) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (32'(w_idx) == i) w_rdata = r_regs[i];
            end
            for (int j = 0; j < NUM_RO; j++) begin
                if (32'(w_idx) == NUM_RW + j) w_rdata = ro_i[32*j +: 32];
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
        assign reg_o[32*g +: 32] = r_regs[g];
    end

    assign HRDATA     = w_rdata;
    assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_ahb_slave_regfile.sv
// Bench for ahb_slave_regfile: one zero-wait and one three-wait instance driven
// by directed and random transfers against a byte-level register model.
module tb_ahb_slave_regfile;

    localparam int NRW = 6;
    localparam int NRO = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn;
    logic [1:0]  sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [63:0] ro;

    logic [1:0]     rdy;
    logic [1:0]     resp;
    logic [31:0]    rdata [2];
    logic [191:0]   rego  [2];
    logic [NRW-1:0] pulse [2];

    int ws [2] = '{0, 3};

    ahb_slave_regfile #(.BASE_ADDR(32'h0), .NUM_RW(NRW), .NUM_RO(NRO), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETN(rstn[0]), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]), .HRDATA(rdata[0]),
        .reg_o(rego[0]), .ro_i(ro), .wr_pulse_o(pulse[0])
    );

    ahb_slave_regfile #(.BASE_ADDR(32'h0), .NUM_RW(NRW), .NUM_RO(NRO), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESETN(rstn[1]), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]), .HRDATA(rdata[1]),
        .reg_o(rego[1]), .ro_i(ro), .wr_pulse_o(pulse[1])
    );

    int npass  = 0;
    int ntotal = 0;
    int nfail  = 0;

    logic [31:0] m_regs [2][NRW];

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] m_pack(input int d);
        logic [191:0] p;
        for (int i = 0; i < NRW; i++) p[32*i +: 32] = m_regs[d][i];
        return p;
    endfunction

    function automatic logic [31:0] m_read(input int d, input int idx);
        if (idx < NRW) return m_regs[d][idx];
        return ro[32*(idx-NRW) +: 32];
    endfunction

    // Non-pipelined transfer: address phase, data phase, then the cycle after completion.
    task automatic do_xfer(input int d, input bit wr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] wd);
        bit          err;
        int          idx;
        int          nbytes;
        logic [31:0] exp_rd;
        logic [5:0]  exp_pulse;
        nbytes = 1 << sz;
        idx    = int'(a / 4);
        err    = (a >= 32'd32) || (sz > 3'd2) || ((a % nbytes) != 0) || (wr && idx >= NRW);
        exp_rd = err ? 32'd0 : m_read(d, idx);
        exp_pulse = '0;

        @(posedge clk); #1;
        sel[d] = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        sel[d] = 1'b0; htrans = 2'b00; hwdata = wd;
        if (err) begin
            @(negedge clk);
            chk("err1_ready", rdy[d], 1'b0);
            chk("err1_resp", resp[d], 1'b1);
            chk("err1_rdata", rdata[d], 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("err2_ready", rdy[d], 1'b1);
            chk("err2_resp", resp[d], 1'b1);
        end else begin
            for (int k = 0; k < ws[d]; k++) begin
                @(negedge clk);
                chk("wait_ready", rdy[d], 1'b0);
                chk("wait_resp", resp[d], 1'b0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("okay_ready", rdy[d], 1'b1);
            chk("okay_resp", resp[d], 1'b0);
            if (!wr) chk("read_data", rdata[d], exp_rd);
            if (wr) begin
                for (int b = int'(a % 4); b < int'(a % 4) + nbytes; b++)
                    m_regs[d][idx][8*b +: 8] = wd[8*b +: 8];
                exp_pulse[idx] = 1'b1;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_pulse", pulse[d], exp_pulse);
        chk("reg_o", rego[d], m_pack(d));
        chk("idle_rdata", rdata[d], 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        rstn = 2'b00; sel = 2'b00; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; hwdata = 32'd0;
        ro = {32'hCAFE_F00D, $urandom()};
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NRW; i++) m_regs[d][i] = 32'd0;

        repeat (3) @(posedge clk);
        #1 rstn = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", rdy[d], 1'b1);
            chk("rst_resp", resp[d], 1'b0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_reg_o", rego[d], 192'd0);
            chk("rst_pulse", pulse[d], 6'd0);
        end

        // Reset lands in the middle of the wait states of a word write.
        @(posedge clk); #1;
        sel[1] = 1'b1; haddr = 32'h8; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        sel[1] = 1'b0; htrans = 2'b00; hwdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("abort_wait_ready", rdy[1], 1'b0);
        #1 rstn[1] = 1'b0;
        #1;
        chk("abort_ready", rdy[1], 1'b1);
        chk("abort_resp", resp[1], 1'b0);
        chk("abort_rdata", rdata[1], 32'd0);
        chk("abort_reg_o", rego[1], 192'd0);
        @(posedge clk); #1 rstn[1] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_pulse", pulse[1], 6'd0);
        chk("abort_reg_after", rego[1], 192'd0);

        do_xfer(1, 1'b0, 32'h1C, 3'd2, 32'd0);
        do_xfer(1, 1'b0, 32'h1E, 3'd1, 32'd0);

        // Back-to-back word write then read of index 1 on the zero-wait instance.
        @(posedge clk); #1;
        sel[0] = 1'b1; haddr = 32'h4; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("b2b_wr_ready", rdy[0], 1'b1);
        @(posedge clk); #1;
        sel[0] = 1'b0; htrans = 2'b00;
        m_regs[0][1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("b2b_pulse", pulse[0], 6'b000010);
        chk("b2b_reg1", rego[0][63:32], 32'hDEAD_BEEF);
        chk("b2b_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("b2b_rd_resp", resp[0], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_pulse_end", pulse[0], 6'b000000);
        chk("b2b_rdata_end", rdata[0], 32'd0);

        do_xfer(0, 1'b1, 32'h6, 3'd0, 32'h00A5_0000);
        chk("byte_lane2", rego[0][63:32], 32'hDEA5_BEEF);
        do_xfer(0, 1'b1, 32'h4, 3'd1, 32'h0000_1234);
        chk("half_low", rego[0][63:32], 32'hDEA5_1234);
        do_xfer(0, 1'b1, 32'h6, 3'd1, 32'h1234_0000);
        chk("half_high", rego[0][63:32], 32'h1234_1234);

        do_xfer(0, 1'b1, 32'h18, 3'd2, 32'hFFFF_FFFF);
        do_xfer(0, 1'b0, 32'h1, 3'd1, 32'd0);
        do_xfer(0, 1'b0, 32'h40, 3'd2, 32'd0);
        chk("err_keep_reg1", rego[0][63:32], 32'h1234_1234);

        for (int n = 0; n < 60; n++) begin
            ra = ($urandom_range(0, 9) == 0) ? (32'h20 << $urandom_range(0, 26)) | 32'h4
                                             : 32'($urandom_range(0, 31));
            do_xfer(n % 3 == 2 ? 1 : 0, 1'($urandom_range(0, 1)), ra,
                    3'($urandom_range(0, 3)), $urandom());
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
